// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory stage plus the MEM/WB pipeline register of the 5-stage ARM core.
//   A load or store starts a fixed-length SRAM access, and the pipeline is
//   frozen while that access is in flight. The stage registers the
//   write-back triple (WB_WB_EN / WB_Dest / WB_Value), which feeds the
//   forwarding unit and the EX operand mux.
//
// Ports
//   clk, rst_n                 core clock, async active-low reset
//   Mem_WB_EN/R_EN/W_EN        EX/MEM control (write-back, load, store)
//   Mem_Dest, ALU_Res, Val_Rm  EX/MEM destination, address/result, store data
//   sram_addr/wdata/we_n       SRAM word address, write data, write strobe
//   sram_rdata                 SRAM read data, valid in the last ACCESS cycle
//   freeze                     stalls PC, IF/ID, ID/EX and EX/MEM
//   WB_WB_EN/WB_Dest/WB_Value  MEM/WB register outputs
//
// Build option
//   MEM_STALL_STAT_EN : adds stall_cnt (frozen cycles) and mem_ops
//                       (completed accesses) counter outputs.
module mem_wb_stage #(
  parameter int WAIT_CYCLES = 4,     // 1..15
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Mem_WB_EN,
  input  logic               Mem_R_EN,
  input  logic               Mem_W_EN,
  input  logic [3:0]         Mem_Dest,
  input  logic [31:0]        ALU_Res,
  input  logic [31:0]        Val_Rm,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  output logic               sram_we_n,
  input  logic [31:0]        sram_rdata,
  output logic               freeze,
  output logic               WB_WB_EN,
  output logic [3:0]         WB_Dest,
  output logic [31:0]        WB_Value
`ifdef MEM_STALL_STAT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        mem_ops
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        mem_req;
  logic        ld_cap;
  logic [31:0] ld_buf;

  assign mem_req = Mem_R_EN | Mem_W_EN;

  // Underflowing addresses wrap modulo 2^32 and are then truncated.
  assign sram_addr  = SRAM_AW'((ALU_Res - 32'(ADDR_BASE)) >> 2);
  assign sram_wdata = Val_Rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ld_cap    = 1'b0;
    freeze    = 1'b0;
    sram_we_n = 1'b1;
    case (state)
      IDLE: begin
        if (mem_req) begin
          state_nx = ACCESS;
          cnt_nx   = '0;
          freeze   = 1'b1;   // stall already in the request cycle
        end
      end
      ACCESS: begin
        freeze    = 1'b1;
        cnt_nx    = cnt + 4'd1;
        // R and W together is treated as a load: never strobe a write then.
        sram_we_n = ~(Mem_W_EN & ~Mem_R_EN);
        if (cnt == LAST) begin
          ld_cap   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;  // EX/MEM advances here, so no re-arm
      default: state_nx = IDLE;
    endcase
    // The state register clears asynchronously, but the request input may
    // still be high; gate so freeze drops the instant reset asserts.
    if (!rst_n) freeze = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ld_buf <= '0;
    else if (ld_cap) ld_buf <= sram_rdata;
  end

  // MEM/WB register: a frozen edge inserts a bubble and holds dest/value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_WB_EN <= 1'b0;
      WB_Dest  <= '0;
      WB_Value <= '0;
    end else if (freeze) begin
      WB_WB_EN <= 1'b0;
    end else begin
      WB_WB_EN <= Mem_WB_EN;
      WB_Dest  <= Mem_Dest;
      WB_Value <= Mem_R_EN ? ld_buf : ALU_Res;
    end
  end

`ifdef MEM_STALL_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      mem_ops   <= '0;
    end else begin
      if (freeze) stall_cnt <= stall_cnt + 32'd1;
      if (ld_cap) mem_ops   <= mem_ops + 32'd1;
    end
  end
`endif

endmodule
